// File: rtl/press_classifier.sv
`timescale 1ns/1ps
// press_classifier: turns a debounced button level plus press/release edge pulses
// into one-cycle short, double, long and auto-repeat gesture pulses.
module press_classifier #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned GAP_CYCLES    = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  input  logic p_edge,
  input  logic n_edge,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_PRESS1,
    S_LONG_HOLD,
    S_GAP,
    S_PRESS2,
    S_WAIT_REL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_d, double_d, long_d, repeat_d;
  logic             pe_c, ne_c;

  // Simultaneous press and release pulses cancel each other out.
  assign pe_c = p_edge & ~n_edge;
  assign ne_c = n_edge & ~p_edge;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    unique case (state_q)
      S_INIT: begin
        state_d = level ? S_WAIT_REL : S_IDLE;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (pe_c) state_d = S_PRESS1;
      end
      S_PRESS1: begin
        if (ne_c) begin
          state_d = S_GAP;
        end else if (cnt_q == LONG_LAST) begin
          state_d = S_LONG_HOLD;
          long_d  = 1'b1;
        end
      end
      S_LONG_HOLD: begin
        if (ne_c) begin
          state_d = S_IDLE;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
      end
      S_GAP: begin
        if (pe_c) begin
          state_d = S_PRESS2;
        end else if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          short_d = 1'b1;
        end
      end
      S_PRESS2: begin
        if (ne_c) begin
          state_d  = S_IDLE;
          double_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d  = S_WAIT_REL;
          double_d = 1'b1;
        end
      end
      S_WAIT_REL: begin
        cnt_d = '0;
        if (ne_c || !level) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Every state change restarts the dwell counter.
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      short_press  <= short_d;
      double_press <= double_d;
      long_press   <= long_d;
      repeat_pulse <= repeat_d;
      busy         <= (state_d != S_IDLE);
    end
  end

endmodule
